// File: rtl/harvest_alarm_pkg.sv
// Shared types and defaults for the harvest vote alarm.
// State encoding, count width and default timing values.
package harvest_alarm_pkg;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_ALARM   = 2'd2,
        ST_MUTED   = 2'd3
    } state_e;

    localparam int CNT_W          = 5;

    localparam int DEF_WINDOW     = 8;
    localparam int DEF_ON_THRESH  = 6;
    localparam int DEF_OFF_THRESH = 2;
    localparam int DEF_BEEP_ON    = 6250000;
    localparam int DEF_BEEP_OFF   = 6250000;
    localparam int DEF_TONE_DIV   = 12500;

endpackage

// File: rtl/beep_envelope_gen.sv
// Buzzer on/off envelope, restarted on every alarm entry.
// Macro BUZZER_TONE_EN adds a square-wave tone for passive piezos.
module beep_envelope_gen
    import harvest_alarm_pkg::*;
#(
    parameter int BEEP_ON  = DEF_BEEP_ON,
    parameter int BEEP_OFF = DEF_BEEP_OFF,
    parameter int TONE_DIV = DEF_TONE_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic run,
    output logic buzzer
);

    localparam int PERIOD = BEEP_ON + BEEP_OFF;
    localparam int EW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    localparam logic [EW-1:0] ON_L   = EW'(BEEP_ON);
    localparam logic [EW-1:0] LAST_L = EW'(PERIOD - 1);

    logic [EW-1:0] env_q, env_d;
    logic          env_on;
    logic          buz_q, buz_d;

    assign env_on = run && (env_q < ON_L);

    // Envelope phase: held at zero when idle, wraps once per beep period.
    always_comb begin
        env_d = env_q;
        if (!run) begin
            env_d = '0;
        end else if (env_q == LAST_L) begin
            env_d = '0;
        end else begin
            env_d = env_q + EW'(1);
        end
    end

`ifdef BUZZER_TONE_EN
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TW-1:0] TLAST_L = TW'(TONE_DIV - 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tone_q, tone_d;

    // Tone divider runs only during the on-phase and restarts each beep.
    always_comb begin
        tcnt_d = tcnt_q;
        tone_d = tone_q;
        if (!env_on) begin
            tcnt_d = '0;
            tone_d = 1'b0;
        end else if (tcnt_q == TLAST_L) begin
            tcnt_d = '0;
            tone_d = ~tone_q;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Tone state registers, frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            tone_q <= 1'b0;
        end else if (ena) begin
            tcnt_q <= tcnt_d;
            tone_q <= tone_d;
        end
    end

    assign buz_d = env_on & tone_q;
`else
    // A tone divider below one cycle is meaningless.
    if (TONE_DIV < 1) begin : g_bad_tone_div
    end

    assign buz_d = env_on;
`endif

    // Envelope and registered buzzer drive, frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_q <= '0;
            buz_q <= 1'b0;
        end else if (ena) begin
            env_q <= env_d;
            buz_q <= buz_d;
        end
    end

    assign buzzer = buz_q & ena;

endmodule

// File: rtl/harvest_vote_alarm.sv
// Majority vote over recent classifier frames with hysteresis.
// Drives harvest buzzer/LED; optional tone via BUZZER_TONE_EN.
module harvest_vote_alarm
    import harvest_alarm_pkg::*;
#(
    parameter int WINDOW     = DEF_WINDOW,
    parameter int ON_THRESH  = DEF_ON_THRESH,
    parameter int OFF_THRESH = DEF_OFF_THRESH,
    parameter int BEEP_ON    = DEF_BEEP_ON,
    parameter int BEEP_OFF   = DEF_BEEP_OFF,
    parameter int TONE_DIV   = DEF_TONE_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             result_valid,
    input  logic             result_class,
    input  logic             ack,
    output logic             buzzer,
    output logic             led_ready,
    output logic             alarm_active,
    output logic [CNT_W-1:0] vote_count,
    output logic             window_full
);

    localparam logic [CNT_W-1:0] WIN_L = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] ON_L  = CNT_W'(ON_THRESH);
    localparam logic [CNT_W-1:0] OFF_L = CNT_W'(OFF_THRESH);

    logic [WINDOW-1:0] win_q, win_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  frm_q, frm_d;
    logic              ack_prev_q, ack_prev_d;
    state_e            state_q, state_d;

    logic              upd;
    logic              ack_rise;
    logic [CNT_W-1:0]  next_cnt;

    assign upd      = ena & result_valid;
    assign ack_rise = ena & ack & ~ack_prev_q;

    // Oldest slot leaves as the new frame enters; empty slots are zero.
    assign next_cnt = cnt_q
                    + CNT_W'(result_class)
                    - CNT_W'(win_q[WINDOW-1]);

    // Window shift, running count, saturating frame count, ack history.
    always_comb begin
        win_d      = win_q;
        cnt_d      = cnt_q;
        frm_d      = frm_q;
        ack_prev_d = ena ? ack : ack_prev_q;
        if (upd) begin
            win_d = {win_q[WINDOW-2:0], result_class};
            cnt_d = next_cnt;
            if (frm_q != WIN_L) begin
                frm_d = frm_q + CNT_W'(1);
            end
        end
    end

    // Next state: clear beats ack, ack beats arm.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL: begin
                if (upd && frm_d == WIN_L) begin
                    state_d = (next_cnt >= ON_L) ? ST_ALARM
                                                 : ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                if (upd && next_cnt >= ON_L) begin
                    state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (upd && next_cnt <= OFF_L) begin
                    state_d = ST_MONITOR;
                end else if (ack_rise) begin
                    state_d = ST_MUTED;
                end
            end
            ST_MUTED: begin
                if (upd && next_cnt <= OFF_L) begin
                    state_d = ST_MONITOR;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // All vote state registers; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            cnt_q      <= '0;
            frm_q      <= '0;
            ack_prev_q <= 1'b0;
            state_q    <= ST_FILL;
        end else if (ena) begin
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            frm_q      <= frm_d;
            ack_prev_q <= ack_prev_d;
            state_q    <= state_d;
        end
    end

    assign alarm_active = (state_q == ST_ALARM);
    assign led_ready    = (state_q == ST_ALARM)
                       || (state_q == ST_MUTED);
    assign vote_count   = cnt_q;
    assign window_full  = (frm_q == WIN_L);

    beep_envelope_gen #(
        .BEEP_ON  (BEEP_ON),
        .BEEP_OFF (BEEP_OFF),
        .TONE_DIV (TONE_DIV)
    ) u_env (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .run    (alarm_active),
        .buzzer (buzzer)
    );

endmodule
